// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit: radix-2 iterative, one bit per clock,
// 32 iterations per MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              is_div_q;
    logic              sgn_q;
    logic              rneg_q;
    logic              dz_q;
    logic [WIDTH-1:0]  rsraw_q;
    logic [WIDTH-1:0]  mcd_q;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  sh_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;
    logic              busy_q;
    logic              done_q;

    // Operand preparation for the launch edge
    logic              signed_op;
    logic              div_op;
    logic              a_neg;
    logic              b_neg;
    logic [WIDTH-1:0]  a_mag;
    logic [WIDTH-1:0]  b_mag;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        div_op    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = signed_op & rs_data[WIDTH-1];
        b_neg     = signed_op & rt_data[WIDTH-1];
        a_mag     = a_neg ? (~rs_data + 1'b1) : rs_data;
        b_mag     = b_neg ? (~rt_data + 1'b1) : rt_data;
    end

    // One radix-2 iteration of either datapath
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic              div_ok;
    logic [WIDTH-1:0]  acc_d;
    logic [WIDTH-1:0]  sh_d;

    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcd_q} : '0);
        div_shift = {acc_q, sh_q[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, mcd_q};
        if (is_div_q) begin
            acc_d = div_ok ? (div_shift[WIDTH-1:0] - mcd_q)
                           : div_shift[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], div_ok};
        end else begin
            acc_d = mul_sum[WIDTH:1];
            sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied only on the final write
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod     = {acc_d, sh_d};
        prod_fix = sgn_q ? (~prod + 1'b1) : prod;
        quot_fix = sgn_q ? (~sh_d + 1'b1) : sh_d;
        rem_fix  = rneg_q ? (~acc_d + 1'b1) : acc_d;
        if (!is_div_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi = rsraw_q;
            res_lo = '1;
        end else begin
            res_hi = rem_fix;
            res_lo = quot_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            rsraw_q  <= '0;
            mcd_q    <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                state_q  <= RUN;
                                busy_q   <= 1'b1;
                                cnt_q    <= '0;
                                is_div_q <= div_op;
                                sgn_q    <= a_neg ^ b_neg;
                                rneg_q   <= a_neg;
                                dz_q     <= div_op && (rt_data == '0);
                                rsraw_q  <= rs_data;
                                acc_q    <= '0;
                                mcd_q    <= div_op ? b_mag : a_mag;
                                sh_q     <= div_op ? a_mag : b_mag;
                            end
                            OP_MTHI: hi_q <= rs_data;
                            OP_MTLO: lo_q <= rs_data;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= res_hi;
                        lo_q    <= res_lo;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases from the
// block's corner behaviour plus randomized ops against an arithmetic model.
module tb_mult_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit / longint arithmetic from the ISA rules
    task automatic model(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] eh,
                         output logic [31:0] el);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = 32'h0;
        el = 32'h0;
        case (o)
            3'b000: begin
                p = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            3'b001: begin
                p = {32'h0, a} * {32'h0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            3'b010: begin
                if (b == 32'h0) begin
                    eh = a;
                    el = 32'hFFFFFFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            3'b011: begin
                if (b == 32'h0) begin
                    eh = a;
                    el = 32'hFFFFFFFF;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where done=1 (or timeout).
    // inj>0 pulses a MULTU 3*3 start at that busy cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int inj,
                          input string tag);
        logic [31:0] eh, el, h0, l0;
        int bc;
        bit seen, held;
        model(o, a, b, eh, el);
        h0 = hi;
        l0 = lo;
        start = 1'b1;
        op = o;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        bc = 0;
        seen = 0;
        held = 1;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bc++;
            if (hi !== h0 || lo !== l0) held = 0;
            start = (inj != 0 && bc == inj);
            if (start) begin
                op = 3'b001;
                rs_data = 32'd3;
                rt_data = 32'd3;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_busycyc"}, 32'(bc), 32'd32);
        chk({tag, "_done"}, {31'b0, seen}, 32'd1);
        chk({tag, "_hold"}, {31'b0, held}, 32'd1);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        logic [2:0] ro;
        logic [31:0] ra, rb;
        int dcnt;
        bit flag;

        rst = 1'b1;
        start = 1'b0;
        op = 3'b000;
        rs_data = 32'h0;
        rt_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu_ff");
        chk("multu_ff_hi_c", hi, 32'hFFFFFFFE);
        chk("multu_ff_lo_c", lo, 32'h00000001);
        @(negedge clk);
        chk("done_1cyc", {31'b0, done}, 32'd0);

        run_op(3'b000, 32'hFFFFFFFD, 32'd5, 0, "mult_neg");
        chk("mult_neg_lo_c", lo, 32'hFFFFFFF1);
        run_op(3'b010, 32'hFFFFFFF9, 32'd2, 0, "div_b2b");
        chk("div_b2b_lo_c", lo, 32'hFFFFFFFD);
        chk("div_b2b_hi_c", hi, 32'hFFFFFFFF);

        run_op(3'b011, 32'd7, 32'd0, 0, "divu_z");
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        chk("div_ovf_lo_c", lo, 32'h80000000);
        run_op(3'b000, 32'h80000000, 32'h80000000, 0, "mult_min");
        chk("mult_min_hi_c", hi, 32'h40000000);
        run_op(3'b010, 32'hFFFFFFF9, 32'd0, 0, "div_z_neg");

        run_op(3'b011, 32'd100, 32'd7, 5, "ign_start");
        chk("ign_lo_c", lo, 32'd14);
        chk("ign_hi_c", hi, 32'd2);
        @(negedge clk);
        chk("ign_no_rerun", {31'b0, busy}, 32'd0);

        start = 1'b1;
        op = 3'b001;
        rs_data = 32'h1234;
        rt_data = 32'h10;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);

        flag = 0;
        start = 1'b1;
        op = 3'b100;
        rs_data = 32'hDEADBEEF;
        @(negedge clk);
        if (busy || done) flag = 1;
        op = 3'b101;
        rs_data = 32'h0000CAFE;
        @(negedge clk);
        if (busy || done) flag = 1;
        start = 1'b0;
        @(negedge clk);
        if (busy || done) flag = 1;
        chk("mthi", hi, 32'hDEADBEEF);
        chk("mtlo", lo, 32'h0000CAFE);
        chk("mt_quiet", {31'b0, flag}, 32'd0);
        start = 1'b1;
        op = 3'b110;
        rs_data = 32'h12345678;
        rt_data = 32'h9;
        @(negedge clk);
        op = 3'b111;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rsv_hi", hi, 32'hDEADBEEF);
        chk("rsv_lo", lo, 32'h0000CAFE);
        chk("rsv_busy", {31'b0, busy}, 32'd0);

        for (int k = 0; k < 16; k++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
            if (ro[1] && $urandom_range(0, 7) == 0) rb = 32'h0;
            run_op(ro, ra, rb, 0, $sformatf("rnd%0d_op%0d", k, ro));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
